// File: rtl/wbc2axil_master.sv
// Wishbone classic (B3) slave to AXI4-Lite master bridge.
// One outstanding transaction. A per-request response timeout raises a WB error.
// If the WB cycle is abandoned, the AXI transaction is still driven to completion.
module wbc2axil_master #(
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_scyc,
  input  logic          i_sstb,
  input  logic          i_swe,
  input  logic [AW-1:0] i_saddr,
  input  logic [DW-1:0] i_sdata,
  input  logic [3:0]    i_ssel,
  output logic          o_sack,
  output logic          o_serr,
  output logic [DW-1:0] o_sdata,
  output logic          o_axi_awvalid,
  input  logic          i_axi_awready,
  output logic [AW+1:0] o_axi_awaddr,
  output logic [2:0]    o_axi_awprot,
  output logic          o_axi_wvalid,
  input  logic          i_axi_wready,
  output logic [DW-1:0] o_axi_wdata,
  output logic [3:0]    o_axi_wstrb,
  input  logic          i_axi_bvalid,
  output logic          o_axi_bready,
  input  logic [1:0]    i_axi_bresp,
  output logic          o_axi_arvalid,
  input  logic          i_axi_arready,
  output logic [AW+1:0] o_axi_araddr,
  output logic [2:0]    o_axi_arprot,
  input  logic          i_axi_rvalid,
  output logic          o_axi_rready,
  input  logic [DW-1:0] i_axi_rdata,
  input  logic [1:0]    i_axi_rresp
);

  // Counter is just wide enough to reach TIMEOUT; it saturates at all-ones.
  localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_WREQ, S_WRESP, S_RREQ, S_RRESP, S_RESP, S_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic          bready_q, bready_d, rready_q, rready_d;
  logic          sack_q, sack_d, serr_q, serr_d;
  logic          we_q, we_d, err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, sdata_q, sdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy, tmo;

  // Only resp[1] distinguishes OKAY/EXOKAY from SLVERR/DECERR.
  logic unused_ok;
  assign unused_ok = &{1'b0, i_axi_bresp[0], i_axi_rresp[0]};

  assign busy = (state_q == S_WREQ) || (state_q == S_WRESP) ||
                (state_q == S_RREQ) || (state_q == S_RRESP);
  assign tmo  = (TIMEOUT != 0) && (cnt_q >= TO_V);

  // State and datapath registers; reset drops every AXI valid/ready at once.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      sack_q    <= 1'b0;
      serr_q    <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      sdata_q   <= '0;
      wstrb_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      sack_q    <= sack_d;
      serr_q    <= serr_d;
      we_q      <= we_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      sdata_q   <= sdata_d;
      wstrb_q   <= wstrb_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic. Priority in wait states: response, then WB abort, then timeout.
  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = bready_q;
    rready_d  = rready_q;
    sack_d    = 1'b0;
    serr_d    = 1'b0;
    we_d      = we_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    sdata_d   = sdata_q;
    wstrb_d   = wstrb_q;
    cnt_d     = cnt_q;

    if (busy && (cnt_q != '1)) cnt_d = cnt_q + CW'(1);

    case (state_q)
      S_IDLE: begin
        // The strobe seen during the ack cycle still belongs to the finished
        // request, so new requests are taken only once ack/err has dropped.
        if (i_scyc && i_sstb && !sack_q && !serr_q) begin
          addr_d = i_saddr;
          cnt_d  = '0;
          we_d   = i_swe;
          if (i_swe) begin
            wdata_d   = i_sdata;
            wstrb_d   = i_ssel;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WREQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RREQ;
          end
        end
      end

      S_WREQ: begin
        if (awvalid_q && i_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && i_axi_wready)   wvalid_d  = 1'b0;
        if (!i_scyc) begin
          state_d = S_DRAIN;
        end else if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_WRESP;
        end else if (tmo) begin
          serr_d  = 1'b1;
          state_d = S_DRAIN;
        end
      end

      S_WRESP: begin
        if (i_axi_bvalid) begin
          bready_d = 1'b0;
          err_d    = i_axi_bresp[1];
          state_d  = i_scyc ? S_RESP : S_IDLE;
        end else if (!i_scyc) begin
          state_d = S_DRAIN;
        end else if (tmo) begin
          serr_d  = 1'b1;
          state_d = S_DRAIN;
        end
      end

      S_RREQ: begin
        if (i_axi_arready) arvalid_d = 1'b0;
        if (!i_scyc) begin
          state_d = S_DRAIN;
        end else if (i_axi_arready) begin
          rready_d = 1'b1;
          state_d  = S_RRESP;
        end else if (tmo) begin
          serr_d  = 1'b1;
          state_d = S_DRAIN;
        end
      end

      S_RRESP: begin
        if (i_axi_rvalid) begin
          rready_d = 1'b0;
          if (i_scyc) begin
            sdata_d = i_axi_rdata;
            err_d   = i_axi_rresp[1];
            state_d = S_RESP;
          end else begin
            state_d = S_IDLE;
          end
        end else if (!i_scyc) begin
          state_d = S_DRAIN;
        end else if (tmo) begin
          serr_d  = 1'b1;
          state_d = S_DRAIN;
        end
      end

      S_RESP: begin
        sack_d  = !err_q;
        serr_d  = err_q;
        state_d = S_IDLE;
      end

      S_DRAIN: begin
        // Finish outstanding address/data handshakes, then swallow the response.
        if (awvalid_q && i_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && i_axi_wready)   wvalid_d  = 1'b0;
        if (arvalid_q && i_axi_arready) arvalid_d = 1'b0;
        if (we_q) begin
          if (bready_q && i_axi_bvalid) begin
            bready_d = 1'b0;
            state_d  = S_IDLE;
          end else if (!awvalid_d && !wvalid_d) begin
            bready_d = 1'b1;
          end
        end else begin
          if (rready_q && i_axi_rvalid) begin
            rready_d = 1'b0;
            state_d  = S_IDLE;
          end else if (!arvalid_d) begin
            rready_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign o_sack        = sack_q;
  assign o_serr        = serr_q;
  assign o_sdata       = sdata_q;
  assign o_axi_awvalid = awvalid_q;
  assign o_axi_awaddr  = {addr_q, 2'b00};
  assign o_axi_awprot  = 3'b000;
  assign o_axi_wvalid  = wvalid_q;
  assign o_axi_wdata   = wdata_q;
  assign o_axi_wstrb   = wstrb_q;
  assign o_axi_bready  = bready_q;
  assign o_axi_arvalid = arvalid_q;
  assign o_axi_araddr  = {addr_q, 2'b00};
  assign o_axi_arprot  = 3'b000;
  assign o_axi_rready  = rready_q;

endmodule

// File: tb/tb_wbc2axil_master.sv
// Directed bench for the WB classic to AXI-Lite bridge, TIMEOUT = 8.
module tb_wbc2axil_master;
  localparam int AW = 30;
  localparam int DW = 32;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_scyc, i_sstb, i_swe;
  logic [AW-1:0] i_saddr;
  logic [DW-1:0] i_sdata;
  logic [3:0]    i_ssel;
  logic          o_sack, o_serr;
  logic [DW-1:0] o_sdata;
  logic          o_axi_awvalid, i_axi_awready;
  logic [AW+1:0] o_axi_awaddr;
  logic [2:0]    o_axi_awprot;
  logic          o_axi_wvalid, i_axi_wready;
  logic [DW-1:0] o_axi_wdata;
  logic [3:0]    o_axi_wstrb;
  logic          i_axi_bvalid, o_axi_bready;
  logic [1:0]    i_axi_bresp;
  logic          o_axi_arvalid, i_axi_arready;
  logic [AW+1:0] o_axi_araddr;
  logic [2:0]    o_axi_arprot;
  logic          i_axi_rvalid, o_axi_rready;
  logic [DW-1:0] i_axi_rdata;
  logic [1:0]    i_axi_rresp;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  wbc2axil_master #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_scyc(i_scyc), .i_sstb(i_sstb), .i_swe(i_swe),
    .i_saddr(i_saddr), .i_sdata(i_sdata), .i_ssel(i_ssel),
    .o_sack(o_sack), .o_serr(o_serr), .o_sdata(o_sdata),
    .o_axi_awvalid(o_axi_awvalid), .i_axi_awready(i_axi_awready),
    .o_axi_awaddr(o_axi_awaddr), .o_axi_awprot(o_axi_awprot),
    .o_axi_wvalid(o_axi_wvalid), .i_axi_wready(i_axi_wready),
    .o_axi_wdata(o_axi_wdata), .o_axi_wstrb(o_axi_wstrb),
    .i_axi_bvalid(i_axi_bvalid), .o_axi_bready(o_axi_bready), .i_axi_bresp(i_axi_bresp),
    .o_axi_arvalid(o_axi_arvalid), .i_axi_arready(i_axi_arready),
    .o_axi_araddr(o_axi_araddr), .o_axi_arprot(o_axi_arprot),
    .i_axi_rvalid(i_axi_rvalid), .o_axi_rready(o_axi_rready),
    .i_axi_rdata(i_axi_rdata), .i_axi_rresp(i_axi_rresp)
  );

  always #5 i_clk = ~i_clk;

  // Edge counter used to measure ack spacing.
  always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;

  // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int t_acc, t_ack, prev_ack;
  logic [DW-1:0] rd_tbl [4];

  initial begin
    rd_tbl[0] = 32'h1111_0001; rd_tbl[1] = 32'h2222_0002;
    rd_tbl[2] = 32'h3333_0003; rd_tbl[3] = 32'h4444_0004;
    i_reset = 1'b1;
    i_scyc = 1'b0; i_sstb = 1'b0; i_swe = 1'b0;
    i_saddr = '0; i_sdata = '0; i_ssel = '0;
    i_axi_awready = 1'b0; i_axi_wready = 1'b0;
    i_axi_bvalid = 1'b0; i_axi_bresp = 2'b00;
    i_axi_arready = 1'b0; i_axi_rvalid = 1'b0;
    i_axi_rdata = '0; i_axi_rresp = 2'b00;
    tick(); tick();
    i_reset = 1'b0;

    // Reset state
    chk("rst_ack", 64'(o_sack), 64'd0);
    chk("rst_err", 64'(o_serr), 64'd0);
    chk("rst_valids", 64'({o_axi_awvalid, o_axi_wvalid, o_axi_arvalid}), 64'd0);
    chk("rst_readys", 64'({o_axi_bready, o_axi_rready}), 64'd0);
    chk("rst_sdata", 64'(o_sdata), 64'd0);
    chk("rst_awaddr", 64'(o_axi_awaddr), 64'd0);

    // 1: write, AW and W accepted together, OKAY
    i_scyc = 1; i_sstb = 1; i_swe = 1;
    i_saddr = 30'h40; i_sdata = 32'hDEADBEEF; i_ssel = 4'b0011;
    i_axi_awready = 1; i_axi_wready = 1;
    tick(); t_acc = cyc_cnt;
    chk("w1_valids", 64'({o_axi_awvalid, o_axi_wvalid}), 64'b11);
    chk("w1_awaddr", 64'(o_axi_awaddr), 64'h100);
    chk("w1_wdata", 64'(o_axi_wdata), 64'hDEADBEEF);
    chk("w1_wstrb", 64'(o_axi_wstrb), 64'b0011);
    chk("w1_prot", 64'({o_axi_awprot, o_axi_arprot}), 64'd0);
    tick();
    chk("w1_hs", 64'({o_axi_awvalid, o_axi_wvalid, o_axi_bready}), 64'b001);
    i_axi_awready = 0; i_axi_wready = 0; i_axi_bvalid = 1; i_axi_bresp = 2'b00;
    tick();
    chk("w1_bready_drop", 64'(o_axi_bready), 64'd0);
    chk("w1_no_early_ack", 64'(o_sack), 64'd0);
    i_axi_bvalid = 0;
    tick(); t_ack = cyc_cnt;
    chk("w1_ack", 64'({o_sack, o_serr}), 64'b10);
    chk("w1_latency", 64'(t_ack - t_acc), 64'd3);
    i_scyc = 0; i_sstb = 0;
    tick();
    chk("w1_ack_pulse", 64'(o_sack), 64'd0);

    // 2: write, W handshakes three cycles before AW
    i_scyc = 1; i_sstb = 1; i_swe = 1;
    i_saddr = 30'h11; i_sdata = 32'h0BADF00D; i_ssel = 4'hF;
    tick();
    chk("w2_valids", 64'({o_axi_awvalid, o_axi_wvalid}), 64'b11);
    i_axi_wready = 1;
    tick();
    chk("w2_w_done", 64'({o_axi_awvalid, o_axi_wvalid}), 64'b10);
    i_axi_wready = 0;
    tick(); tick();
    chk("w2_aw_held", 64'({o_axi_awvalid, o_axi_bready}), 64'b10);
    i_axi_awready = 1;
    tick();
    chk("w2_aw_done", 64'({o_axi_awvalid, o_axi_bready}), 64'b01);
    i_axi_awready = 0; i_axi_bvalid = 1;
    tick();
    i_axi_bvalid = 0;
    tick();
    chk("w2_ack", 64'({o_sack, o_serr}), 64'b10);
    i_scyc = 0; i_sstb = 0;
    tick();
    chk("w2_single_ack", 64'(o_sack), 64'd0);

    // 3: read, SLVERR
    i_scyc = 1; i_sstb = 1; i_swe = 0; i_saddr = 30'h22; i_axi_arready = 1;
    tick();
    chk("r3_arvalid", 64'(o_axi_arvalid), 64'd1);
    chk("r3_araddr", 64'(o_axi_araddr), 64'h88);
    tick();
    chk("r3_hs", 64'({o_axi_arvalid, o_axi_rready}), 64'b01);
    i_axi_arready = 0; i_axi_rvalid = 1; i_axi_rdata = 32'h12345678; i_axi_rresp = 2'b10;
    tick();
    chk("r3_rready_drop", 64'(o_axi_rready), 64'd0);
    i_axi_rvalid = 0; i_axi_rresp = 2'b00;
    tick();
    chk("r3_err", 64'({o_sack, o_serr}), 64'b01);
    chk("r3_sdata", 64'(o_sdata), 64'h12345678);
    i_scyc = 0; i_sstb = 0;
    tick();
    chk("r3_err_pulse", 64'(o_serr), 64'd0);

    // 4: read aborted while AR stalls; drained response must not reach o_sdata
    i_scyc = 1; i_sstb = 1; i_swe = 0; i_saddr = 30'h33;
    tick();
    chk("r4_arvalid", 64'(o_axi_arvalid), 64'd1);
    i_scyc = 0; i_sstb = 0;
    tick();
    chk("r4_drain_hold", 64'({o_axi_arvalid, o_axi_rready}), 64'b10);
    tick(); tick(); tick();
    chk("r4_still_held", 64'({o_axi_arvalid, o_sack, o_serr}), 64'b100);
    i_axi_arready = 1;
    tick();
    chk("r4_ar_done", 64'({o_axi_arvalid, o_axi_rready}), 64'b01);
    i_axi_arready = 0; i_axi_rvalid = 1; i_axi_rdata = 32'hAAAA5555;
    tick();
    i_axi_rvalid = 0;
    chk("r4_consumed", 64'(o_axi_rready), 64'd0);
    chk("r4_no_resp", 64'({o_sack, o_serr}), 64'b00);
    chk("r4_sdata_kept", 64'(o_sdata), 64'h12345678);
    // follow-up write after the drain
    i_scyc = 1; i_sstb = 1; i_swe = 1;
    i_saddr = 30'h44; i_sdata = 32'h5555AAAA; i_ssel = 4'hC;
    i_axi_awready = 1; i_axi_wready = 1;
    tick();
    chk("w4_awaddr", 64'(o_axi_awaddr), 64'h110);
    tick();
    i_axi_awready = 0; i_axi_wready = 0; i_axi_bvalid = 1;
    tick();
    i_axi_bvalid = 0;
    tick();
    chk("w4_ack", 64'({o_sack, o_serr}), 64'b10);
    chk("w4_sdata_kept", 64'(o_sdata), 64'h12345678);
    i_scyc = 0; i_sstb = 0;
    tick();

    // 5: timeout with bvalid arriving late
    i_scyc = 1; i_sstb = 1; i_swe = 1; i_saddr = 30'h55; i_sdata = 32'hCAFE0000;
    i_axi_awready = 1; i_axi_wready = 1;
    tick();
    tick();
    chk("t5_bready", 64'(o_axi_bready), 64'd1);
    i_axi_awready = 0; i_axi_wready = 0;
    for (int k = 2; k <= 8; k++) tick();
    chk("t5_no_err_yet", 64'(o_serr), 64'd0);
    tick();
    chk("t5_err", 64'({o_sack, o_serr}), 64'b01);
    i_scyc = 0; i_sstb = 0;
    tick();
    chk("t5_err_pulse", 64'(o_serr), 64'd0);
    chk("t5_drain_bready", 64'(o_axi_bready), 64'd1);
    for (int k = 11; k <= 19; k++) tick();
    i_axi_bvalid = 1;
    tick();
    i_axi_bvalid = 0;
    chk("t5_drained", 64'({o_axi_bready, o_sack, o_serr}), 64'b000);

    // 6: back-to-back reads with strobe held high
    i_scyc = 1; i_sstb = 1; i_swe = 0; i_axi_arready = 1;
    prev_ack = 0;
    for (int i = 0; i < 4; i++) begin
      i_saddr = 30'h60 + 30'(i);
      tick();
      chk("b6_araddr", 64'(o_axi_araddr), 64'((32'h60 + 32'(i)) << 2));
      tick();
      chk("b6_rready", 64'(o_axi_rready), 64'd1);
      i_axi_rvalid = 1; i_axi_rdata = rd_tbl[i];
      tick();
      i_axi_rvalid = 0;
      tick();
      chk("b6_ack", 64'({o_sack, o_serr}), 64'b10);
      chk("b6_sdata", 64'(o_sdata), 64'(rd_tbl[i]));
      if (i > 0) chk("b6_spacing", 64'(cyc_cnt - prev_ack), 64'd5);
      prev_ack = cyc_cnt;
      tick();
      chk("b6_gap", 64'({o_sack, o_axi_arvalid}), 64'b00);
    end
    i_scyc = 0; i_sstb = 0; i_axi_arready = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
